// File: rtl/jt12_reg_gen.sv
// jt12_reg_gen: time-multiplexed operator/channel register file.
//
// A slot counter walks every (operator, channel) pair once per NCH*NOP
// cycles. Operator registers live in an NSLOT-deep circular shift ring and
// channel registers in an NCH-deep ring. Both rings rotate every cycle, so
// entry 0 of each ring always belongs to the current slot.
//
// A write request is latched into a holding register. It is then merged into
// the ring when its target slot next comes around.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_valid/wr_sel/wr_ch/   write request (wr_sel 0 = operator, 1 = channel),
//   wr_op/wr_data/wr_mask    per-bit mask, channel writes use the LSBs
//   busy, wr_err             request pending / out-of-range channel pulse
//   cur_ch, cur_op, zero     current slot, zero high in slot (op 0, ch 0)
//   op_dout, ch_dout         registers of the current slot
//
// Optional feature (macro JT12_REG_RDBACK_EN): readback port
//   rd_req/rd_sel/rd_ch/rd_op in, rd_valid/rd_data out.
module jt12_reg_gen #(
  parameter int NCH = 6,
  parameter int NOP = 4,
  parameter int OPW = 44,
  parameter int CHW = 31,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int OW = (NOP > 1) ? $clog2(NOP) : 1,
  localparam int DW = (OPW > CHW) ? OPW : CHW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic          wr_sel,
  input  logic [CW-1:0] wr_ch,
  input  logic [OW-1:0] wr_op,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] wr_mask,
  output logic          busy,
  output logic          wr_err,
  output logic [CW-1:0] cur_ch,
  output logic [OW-1:0] cur_op,
  output logic          zero,
  output logic [OPW-1:0] op_dout,
  output logic [CHW-1:0] ch_dout
`ifdef JT12_REG_RDBACK_EN
  ,
  input  logic          rd_req,
  input  logic          rd_sel,
  input  logic [CW-1:0] rd_ch,
  input  logic [OW-1:0] rd_op,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data
`endif
);

  localparam int NSLOT = NCH * NOP;
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
  localparam logic [OW-1:0] OP_LAST = OW'(NOP - 1);
  localparam logic [CW:0]   NCH_V   = (CW + 1)'(NCH);

  logic [CW-1:0]  cur_ch_q, cur_ch_d;
  logic [OW-1:0]  cur_op_q, cur_op_d;
  logic [OPW-1:0] op_ring_q [NSLOT];
  logic [OPW-1:0] op_ring_d [NSLOT];
  logic [CHW-1:0] ch_ring_q [NCH];
  logic [CHW-1:0] ch_ring_d [NCH];

  logic           busy_q, busy_d;
  logic           wr_err_q, wr_err_d;
  logic           req_sel_q, req_sel_d;
  logic [CW-1:0]  req_ch_q, req_ch_d;
  logic [OW-1:0]  req_op_q, req_op_d;
  logic [DW-1:0]  req_data_q, req_data_d;
  logic [DW-1:0]  req_mask_q, req_mask_d;

  logic           op_hit, ch_hit;
  logic [OPW-1:0] op_merge;
  logic [CHW-1:0] ch_merge;

  // Pending write targets the entry that is current this cycle.
  always_comb begin
    op_hit   = busy_q && !req_sel_q && (cur_ch_q == req_ch_q) && (cur_op_q == req_op_q);
    ch_hit   = busy_q && req_sel_q && (cur_ch_q == req_ch_q);
    op_merge = (op_ring_q[0] & ~req_mask_q[OPW-1:0]) | (req_data_q[OPW-1:0] & req_mask_q[OPW-1:0]);
    ch_merge = (ch_ring_q[0] & ~req_mask_q[CHW-1:0]) | (req_data_q[CHW-1:0] & req_mask_q[CHW-1:0]);
  end

  // Slot counter: channel is the fast index, operator the slow one.
  always_comb begin
    cur_ch_d = cur_ch_q + CW'(1);
    cur_op_d = cur_op_q;
    if (cur_ch_q == CH_LAST) begin
      cur_ch_d = '0;
      cur_op_d = (cur_op_q == OP_LAST) ? '0 : cur_op_q + OW'(1);
    end
  end

  // Rings rotate toward entry 0. The current entry re-enters at the tail,
  // merged with the pending write when the slot matches.
  always_comb begin
    for (int i = 0; i < NSLOT - 1; i++) op_ring_d[i] = op_ring_q[i+1];
    op_ring_d[NSLOT-1] = op_hit ? op_merge : op_ring_q[0];
    for (int i = 0; i < NCH - 1; i++) ch_ring_d[i] = ch_ring_q[i+1];
    ch_ring_d[NCH-1] = ch_hit ? ch_merge : ch_ring_q[0];
  end

  // Request capture. A request is captured only when idle. Because busy
  // rises a cycle later, a request aimed at the current slot waits a full
  // revolution.
  always_comb begin
    busy_d     = busy_q;
    wr_err_d   = 1'b0;
    req_sel_d  = req_sel_q;
    req_ch_d   = req_ch_q;
    req_op_d   = req_op_q;
    req_data_d = req_data_q;
    req_mask_d = req_mask_q;
    if (busy_q) begin
      if (op_hit || ch_hit) busy_d = 1'b0;
    end else if (wr_valid) begin
      if ({1'b0, wr_ch} < NCH_V) begin
        busy_d     = 1'b1;
        req_sel_d  = wr_sel;
        req_ch_d   = wr_ch;
        req_op_d   = wr_op;
        req_data_d = wr_data;
        req_mask_d = wr_mask;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch_q   <= '0;
      cur_op_q   <= '0;
      busy_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      req_sel_q  <= 1'b0;
      req_ch_q   <= '0;
      req_op_q   <= '0;
      req_data_q <= '0;
      req_mask_q <= '0;
      for (int i = 0; i < NSLOT; i++) op_ring_q[i] <= '0;
      for (int i = 0; i < NCH; i++)   ch_ring_q[i] <= '0;
    end else begin
      cur_ch_q   <= cur_ch_d;
      cur_op_q   <= cur_op_d;
      busy_q     <= busy_d;
      wr_err_q   <= wr_err_d;
      req_sel_q  <= req_sel_d;
      req_ch_q   <= req_ch_d;
      req_op_q   <= req_op_d;
      req_data_q <= req_data_d;
      req_mask_q <= req_mask_d;
      op_ring_q  <= op_ring_d;
      ch_ring_q  <= ch_ring_d;
    end
  end

  assign cur_ch  = cur_ch_q;
  assign cur_op  = cur_op_q;
  assign zero    = (cur_ch_q == '0) && (cur_op_q == '0);
  assign busy    = busy_q;
  assign wr_err  = wr_err_q;
  assign op_dout = op_ring_q[0];
  assign ch_dout = ch_ring_q[0];

`ifdef JT12_REG_RDBACK_EN
  logic          rd_pend_q, rd_pend_d;
  logic          rd_sel_q, rd_sel_d;
  logic [CW-1:0] rd_ch_q, rd_ch_d;
  logic [OW-1:0] rd_op_q, rd_op_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_hit;
  logic [DW-1:0] rd_val;

  // A read served in the same slot as a pending write returns the merged value.
  always_comb begin
    rd_hit = rd_pend_q && (cur_ch_q == rd_ch_q) && (rd_sel_q || (cur_op_q == rd_op_q));
    if (rd_sel_q) rd_val = DW'(ch_hit ? ch_merge : ch_ring_q[0]);
    else          rd_val = DW'(op_hit ? op_merge : op_ring_q[0]);
    rd_pend_d  = rd_pend_q;
    rd_sel_d   = rd_sel_q;
    rd_ch_d    = rd_ch_q;
    rd_op_d    = rd_op_q;
    rd_valid_d = rd_hit;
    rd_data_d  = rd_hit ? rd_val : rd_data_q;
    if (rd_pend_q) begin
      if (rd_hit) rd_pend_d = 1'b0;
    end else if (rd_req && ({1'b0, rd_ch} < NCH_V)) begin
      rd_pend_d = 1'b1;
      rd_sel_d  = rd_sel;
      rd_ch_d   = rd_ch;
      rd_op_d   = rd_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_ch_q    <= '0;
      rd_op_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_sel_q   <= rd_sel_d;
      rd_ch_q    <= rd_ch_d;
      rd_op_q    <= rd_op_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_jt12_reg_gen.sv
// Directed testbench for jt12_reg_gen with default parameters (NCH=6, NOP=4).
// The bench tracks the slot index k itself, counted from reset release.
// Expected register contents are kept in small arrays that are updated by hand.
module tb_jt12_reg_gen;
  localparam int NCH = 6, NOP = 4, OPW = 44, CHW = 31;
  localparam int CW = 3, OW = 2, DW = 44, NSLOT = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_sel;
  logic [CW-1:0] wr_ch;
  logic [OW-1:0] wr_op;
  logic [DW-1:0] wr_data, wr_mask;
  logic          busy, wr_err, zero;
  logic [CW-1:0] cur_ch;
  logic [OW-1:0] cur_op;
  logic [OPW-1:0] op_dout;
  logic [CHW-1:0] ch_dout;
`ifdef JT12_REG_RDBACK_EN
  logic          rd_req, rd_sel, rd_valid;
  logic [CW-1:0] rd_ch;
  logic [OW-1:0] rd_op;
  logic [DW-1:0] rd_data;
`endif

  jt12_reg_gen #(.NCH(NCH), .NOP(NOP), .OPW(OPW), .CHW(CHW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_op(wr_op),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .busy(busy), .wr_err(wr_err),
    .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero),
    .op_dout(op_dout), .ch_dout(ch_dout)
`ifdef JT12_REG_RDBACK_EN
    , .rd_req(rd_req), .rd_sel(rd_sel), .rd_ch(rd_ch), .rd_op(rd_op),
    .rd_valid(rd_valid), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int k = 0;
  int cnt;
  logic [OPW-1:0] exp_op [NSLOT];
  logic [CHW-1:0] exp_ch [NCH];
  logic [DW-1:0]  all1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < NSLOT && (k % NSLOT) != s; i++) step();
  endtask

  task automatic wr(input logic sel, input logic [CW-1:0] ch, input logic [OW-1:0] op,
                    input logic [DW-1:0] data, input logic [DW-1:0] mask);
    wr_valid = 1'b1; wr_sel = sel; wr_ch = ch; wr_op = op; wr_data = data; wr_mask = mask;
    step();
    wr_valid = 1'b0;
  endtask

  // Called right after wr(): counts cycles with busy high, bounded.
  task automatic wait_idle(output int n);
    n = busy ? 1 : 0;
    for (int i = 0; i < 40 && busy; i++) begin
      step();
      if (busy) n++;
    end
    chk("busy_timeout", busy, 1'b0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NSLOT; i++) exp_op[i] = '0;
    for (int i = 0; i < NCH; i++)   exp_ch[i] = '0;
  endtask

  // Walk one full revolution, checking the slot counter and both rings.
  task automatic check_ring(input string tag);
    for (int i = 0; i < NSLOT; i++) begin
      chk({tag, "_cur_ch"}, cur_ch, (k % NCH));
      chk({tag, "_cur_op"}, cur_op, ((k / NCH) % NOP));
      chk({tag, "_zero"}, zero, ((k % NSLOT) == 0));
      chk({tag, "_op_dout"}, op_dout, exp_op[k % NSLOT]);
      chk({tag, "_ch_dout"}, ch_dout, exp_ch[k % NCH]);
      step();
    end
  endtask

  initial begin
    all1 = '1;
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_ch = '0; wr_op = '0;
    wr_data = '0; wr_mask = '0;
`ifdef JT12_REG_RDBACK_EN
    rd_req = 1'b0; rd_sel = 1'b0; rd_ch = '0; rd_op = '0;
`endif
    clear_model();

    // Reset state, held over several edges
    step(); step(); step();
    chk("rst_zero", zero, 1'b1);
    chk("rst_cur_ch", cur_ch, 0);
    chk("rst_cur_op", cur_op, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_op_dout", op_dout, 0);
    rst = 1'b0;
    k = 0;

    // Sequencing plus all-zero contents over two revolutions
    check_ring("seq0");
    check_ring("seq1");

    // Masked operator write issued while its own slot (op2,ch3)=15 is current
    wait_slot(15);
    wr(1'b0, 3'd3, 2'd2, all1, 44'h00F);
    chk("opw_busy_set", busy, 1'b1);
    wait_idle(cnt);
    chk("opw_busy_cycles", cnt, 24);
    exp_op[15] = 44'h00F;
    check_ring("opw");

    // Channel write to ch1 issued in slot with ch2 current: busy for ch3,4,5,0,1
    wait_slot(2);
    wr(1'b1, 3'd1, 2'd0, 44'h5A, all1);
    wait_idle(cnt);
    chk("chw_busy_cycles", cnt, 5);
    exp_ch[1] = 31'h5A;
    check_ring("chw");

    // Second request while busy is ignored
    wait_slot(1);
    wr(1'b0, 3'd0, 2'd0, 44'hABC, all1);
    wr(1'b0, 3'd1, 2'd1, 44'h123, all1);
    chk("ign_busy_held", busy, 1'b1);
    wait_idle(cnt);
    exp_op[0] = 44'hABC;
    check_ring("ign");

    // Out-of-range channel
    wr(1'b0, 3'd6, 2'd0, all1, all1);
    chk("err_pulse", wr_err, 1'b1);
    chk("err_busy", busy, 1'b0);
    step();
    chk("err_clear", wr_err, 1'b0);
    chk("err_busy2", busy, 1'b0);

    // Reset while a write to slot (op3,ch5) is pending
    wait_slot(0);
    wr(1'b0, 3'd5, 2'd3, all1, all1);
    step(); step();
    chk("rstb_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstb_busy", busy, 1'b0);
    chk("rstb_zero", zero, 1'b1);
    chk("rstb_op_dout", op_dout, 0);
    step();
    rst = 1'b0;
    k = 0;
    clear_model();
    check_ring("rstb");

`ifdef JT12_REG_RDBACK_EN
    wait_slot(15);
    wr(1'b0, 3'd3, 2'd2, all1, 44'h00F);
    wait_idle(cnt);
    rd_req = 1'b1; rd_sel = 1'b0; rd_ch = 3'd3; rd_op = 2'd2;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 40 && !rd_valid; i++) step();
    chk("rd_valid", rd_valid, 1'b1);
    chk("rd_data", rd_data, 44'h00F);
    step();
    chk("rd_valid_pulse", rd_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/jt12_reg_gen.md
JT12_REG_GEN -- requirements
Module: jt12_reg_gen

Interface
REQ-001 SHALL have parameter NCH, default 6: channels per slot cycle, 2..8.
REQ-002 SHALL have parameter NOP, default 4: operators per channel, 2 or 4.
REQ-003 SHALL have parameter OPW, default 44: operator register width.
REQ-004 SHALL have parameter CHW, default 31: channel register width; CW = clog2(NCH), OW = clog2(NOP).
REQ-005 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-007 SHALL have ports wr_valid in 1, wr_sel in 1 (0 = operator reg, 1 = channel reg), wr_ch in CW, wr_op in OW: write request.
REQ-008 SHALL have ports wr_data in max(OPW,CHW), wr_mask in max(OPW,CHW): write data and per-bit enable; LSBs used for channel writes.
REQ-009 SHALL have ports busy out 1 and wr_err out 1.
REQ-010 SHALL have ports cur_ch out CW, cur_op out OW, zero out 1: current slot.
REQ-011 SHALL have ports op_dout out OPW and ch_dout out CHW: registers of the current slot.

Function
REQ-012 SHALL advance the slot every cycle: cur_ch 0..NCH-1, then wrap to 0 and increment cur_op modulo NOP; NSLOT = NCH*NOP.
REQ-013 SHALL assert zero in exactly the cycle the slot is (op 0, ch 0).
REQ-014 SHALL store operator data in an NSLOT-deep circular shift ring and channel data in an NCH-deep ring, both advancing every cycle, with op_dout/ch_dout showing the current-slot entry.
REQ-015 SHALL accept a write when wr_valid=1 and busy=0, capturing sel/ch/op/data/mask and setting busy the next cycle.
REQ-016 SHALL ignore wr_valid while busy=1; the held request is not modified.
REQ-017 SHALL reject a write with wr_ch >= NCH: busy stays 0, wr_err pulses high one cycle.
REQ-018 SHALL apply an operator write in the first busy cycle where cur_ch/cur_op match: the entry re-entering the ring is (old & ~mask) | (data & mask).
REQ-019 SHALL apply a channel write in the first busy cycle where cur_ch matches, regardless of cur_op.
REQ-020 SHALL clear busy the cycle after the write is applied; op_dout reflects the new value the next time that slot is presented.
REQ-021 SHALL bound busy duration to NSLOT cycles (operator) or NCH cycles (channel).
REQ-022 SHALL, for a request accepted in the cycle its target slot is current, apply it on the next occurrence of that slot, not the current one.
REQ-023 SHALL leave unmasked bits and all non-target entries unchanged.

Reset
REQ-024 SHALL, with rst high, clear both rings to 0, set cur_ch=0, cur_op=0, zero=1, busy=0, wr_err=0, drop any held request.
REQ-025 SHALL abort a pending write if rst asserts while busy; the target entry remains 0.
REQ-026 SHALL resume slot sequencing from (0,0) on the first edge after rst deasserts.

Configuration
REQ-027 SHALL support macro JT12_REG_RDBACK_EN.
REQ-028 SHALL, with JT12_REG_RDBACK_EN defined, add ports rd_req in 1, rd_sel in 1, rd_ch in CW, rd_op in OW, rd_valid out 1, rd_data out max(OPW,CHW); a read is accepted when no read is pending, is served at the next matching slot with rd_valid pulsing one cycle, and a same-slot pending write is returned post-merge.
REQ-029 SHALL, without JT12_REG_RDBACK_EN, omit those ports and all read logic.

Verification
REQ-030 SHALL verify reset: after rst, zero=1, cur_ch=0, cur_op=0, busy=0, all op_dout=0 over NSLOT cycles.
REQ-031 SHALL verify sequencing: NCH=6, NOP=4 -> zero pulses every 24 cycles; cur_op increments after cur_ch=5.
REQ-032 SHALL verify masked write: op=2, ch=3, data=all 1s, mask=0x00F -> slot (2,3) reads 0x00F, others 0, busy <= 24 cycles.
REQ-033 SHALL verify channel write: ch=1, data=0x5A -> ch_dout=0x5A at ch 1 for every op; busy <= 6 cycles.
REQ-034 SHALL verify corner cases: wr_valid while busy -> ignored; wr_ch=6 with NCH=6 -> wr_err one cycle, busy=0; rst mid-busy -> target stays 0.
REQ-035 SHALL verify readback (macro on): after the REQ-032 write, rd of (2,3) -> rd_valid one cycle, rd_data=0x00F.
